seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles per digit slot (must be at least 4).
REQ-002 SHALL have parameter DEAD_CYC, default 16, meaning blanking cycles at the start of each slot (must be less than SCAN_DIV).
REQ-003 SHALL have port clk, input, 1 bit: the single clock. All logic is synchronous to it.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port seg_we, input, 1 bit: CPU IO write strobe for the display (io_write qualified by seg_ctrl).
REQ-006 SHALL have port seg_addr, input, 2 bits: register select. 0 = digits 3..0; 1 = digits 7..4; 2 = control; 3 = reserved.
REQ-007 SHALL have port seg_wdata, input, 16 bits: write data. For addr 0/1, one hex nibble per digit, LSB nibble = lowest digit. For addr 2, [7:0] = digit enable mask and [15:8] = dp mask.
REQ-008 SHALL have port tub_sel, output, 8 bits: active-high digit selects; bit i = digit i.
REQ-009 SHALL have port seg30, output, 8 bits: segments {a,b,c,d,e,f,g,dp}, active-high, for digits 3..0.
REQ-010 SHALL have port seg74, output, 8 bits: segments for digits 7..4, same encoding as seg30.

Function
REQ-011 SHALL keep two register sets, pending (CPU-written) and active (displayed), each holding: digits (32 bits), en_mask (8 bits), dp_mask (8 bits).
REQ-012 SHALL, when seg_we=1, write seg_wdata into the pending field selected by seg_addr on that clock edge; writes with addr 3 SHALL be ignored.
REQ-013 SHALL run slot counter cnt from 0 to SCAN_DIV-1 and then wrap to 0; on each wrap, 2-bit idx SHALL advance, with 3 wrapping to 0.
REQ-014 SHALL copy pending to active on the edge where idx wraps from 3 to 0 (frame boundary), so the displayed frame never tears.
REQ-015 SHALL, if a write coincides with the frame-boundary edge, load active with the newly written value (write bypass).
REQ-016 SHALL scan both groups together: slot idx drives digit idx in seg30 and digit idx+4 in seg74.
REQ-017 SHALL, while cnt < DEAD_CYC, drive tub_sel = 0; otherwise tub_sel[idx] = en_mask[idx] and tub_sel[idx+4] = en_mask[idx+4], with all other bits 0.
REQ-018 SHALL drive each seg output as font(nibble) OR dp_mask bit (bit 0), or 8'h00 when that digit's enable bit is 0.
REQ-019 SHALL use this font: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E.
REQ-020 SHALL register all outputs: each output reflects the cnt/idx/active state of the previous cycle (1-cycle latency).
REQ-021 SHALL, as a two-state FSM per slot (BLANK while cnt<DEAD_CYC, DRIVE otherwise), make the BLANK->DRIVE transition at cnt==DEAD_CYC and DRIVE->BLANK at the wrap.

Reset
REQ-022 SHALL, on rstn=0 at a clock edge, set cnt=0, idx=0, pending and active digits=0, en_mask=FF, dp_mask=00, tub_sel=00, seg30=00, seg74=00.
REQ-023 SHALL, on reset asserted mid-slot or mid-frame, abandon the slot and drop writes in that cycle; scanning restarts at idx 0 in BLANK.

Structure
REQ-024 SHALL place these in shared package seg_pkg: font constants, seg_addr encodings (SEG_ADDR_LO/HI/CTRL), and reset constants.
REQ-025 SHALL instantiate combinational sub-module seg_hex_font (4-bit nibble -> 8-bit segments) twice, once per group.

Verification (SCAN_DIV=8, DEAD_CYC=2)
REQ-026 SHALL cover reset release: tub_sel=00 for cycles 1-2 after release, then 01/10 pairs (tub_sel=11) showing seg30=seg74=FC.
REQ-027 SHALL cover a write: addr0=0x3210 and addr1=0x7654 mid-frame -> old digits persist until the frame boundary; the next frame shows seg30 60, DA, F2 in slots 1-3 and seg74 66, B6, BE, E0 in slots 0-3.
REQ-028 SHALL cover the control register: addr2=0x01FE -> digit 0 blanked (tub_sel bit0 = 0, seg30=00 in slot 0) and dp on digit 0 suppressed; digit 8-bit mask 0x01 in dp only affects enabled digits.
REQ-029 SHALL cover the simultaneous case: write addr0=0x000F on the frame-boundary edge -> slot 0 of the new frame shows seg30=8E.
REQ-030 SHALL cover the addr 3 write: write with addr 3 -> no output or register change.
REQ-031 SHALL cover reset mid-slot: rstn low during idx 2, cnt 5 -> next cycle outputs 00, digits 0, idx 0, cnt 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   FONT_TABLE   : hex nibble -> {a,b,c,d,e,f,g,dp} segment pattern (active-high)
//   SEG_ADDR_*   : register select encodings for seg_addr
//   seg_regs_t   : one register set (digits, enable mask, dp mask)
//   *_RESET      : reset values for register sets and outputs
package seg_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned NUM_DIG = 8;
    localparam int unsigned SEG_W   = 8;

    // Index 15 is leftmost: F, E, d, C, b, A, 9 ... 0
    localparam logic [15:0][SEG_W-1:0] FONT_TABLE = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    localparam logic [1:0] SEG_ADDR_LO   = 2'd0;
    localparam logic [1:0] SEG_ADDR_HI   = 2'd1;
    localparam logic [1:0] SEG_ADDR_CTRL = 2'd2;

    typedef struct packed {
        logic [NUM_DIG*DIGIT_W-1:0] digits;
        logic [NUM_DIG-1:0]         en_mask;
        logic [NUM_DIG-1:0]         dp_mask;
    } seg_regs_t;

    localparam seg_regs_t        REG_RESET = '{digits: 32'h0, en_mask: 8'hFF, dp_mask: 8'h00};
    localparam logic [SEG_W-1:0] SEG_RESET = 8'h00;
    localparam logic [NUM_DIG-1:0] TUB_RESET = 8'h00;

endpackage

// File: rtl/seg_hex_font.sv
// Combinational hex-to-segment decoder.
//   nibble : hex digit value
//   seg_c  : {a,b,c,d,e,f,g,dp} pattern, dp always 0
module seg_hex_font
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] nibble,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = FONT_TABLE[nibble];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for two groups of four seven-segment digits.
// A CPU writes a pending register set; it is copied to the displayed set
// only at frame boundaries so a frame never shows a half-updated value.
//   clk, rstn  : clock, synchronous active-low reset
//   seg_we     : write strobe
//   seg_addr   : 0 = digits 3..0, 1 = digits 7..4, 2 = {dp_mask, en_mask}, 3 = ignored
//   seg_wdata  : write data
//   tub_sel    : active-high digit selects
//   seg30/74   : segment patterns for digit groups 3..0 and 7..4
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DEAD_CYC = 16
)(
    input  logic                clk,
    input  logic                rstn,
    input  logic                seg_we,
    input  logic [1:0]          seg_addr,
    input  logic [15:0]         seg_wdata,
    output logic [NUM_DIG-1:0]  tub_sel,
    output logic [SEG_W-1:0]    seg30,
    output logic [SEG_W-1:0]    seg74
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    // With no dead time every slot starts directly in DRIVE
    localparam state_t ST_INIT = (DEAD_CYC == 0) ? ST_DRIVE : ST_BLANK;

    state_t             state, state_next_c;
    logic [CNT_W-1:0]   cnt, cnt_next_c;
    logic [1:0]         idx, idx_next_c;
    seg_regs_t          pending, pending_next_c, active;
    logic               wrap_c, frame_c;
    logic [DIGIT_W-1:0] nib_lo_c, nib_hi_c;
    logic [SEG_W-1:0]   font_lo_c, font_hi_c;
    logic [NUM_DIG-1:0] tub_sel_c;
    logic [SEG_W-1:0]   seg30_c, seg74_c;

    // Slot counter, digit index and pending-register update
    always_comb begin
        wrap_c         = (cnt == CNT_W'(SCAN_DIV - 1));
        frame_c        = wrap_c && (idx == 2'd3);
        cnt_next_c     = wrap_c ? '0 : cnt + CNT_W'(1);
        idx_next_c     = wrap_c ? idx + 2'd1 : idx;
        pending_next_c = pending;
        if (seg_we) begin
            case (seg_addr)
                SEG_ADDR_LO:   pending_next_c.digits[15:0]  = seg_wdata;
                SEG_ADDR_HI:   pending_next_c.digits[31:16] = seg_wdata;
                SEG_ADDR_CTRL: begin
                    pending_next_c.en_mask = seg_wdata[7:0];
                    pending_next_c.dp_mask = seg_wdata[15:8];
                end
                default: ;
            endcase
        end
    end

    assign nib_lo_c = active.digits[{idx, 2'b00} +: DIGIT_W];
    assign nib_hi_c = active.digits[{1'b1, idx, 2'b00} +: DIGIT_W];

    seg_hex_font u_font_lo (.nibble(nib_lo_c), .seg_c(font_lo_c));
    seg_hex_font u_font_hi (.nibble(nib_hi_c), .seg_c(font_hi_c));

    // Slot FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_INIT;
        else       state <= state_next_c;
    end

    // Slot FSM next state and next output values
    always_comb begin
        state_next_c = state;
        tub_sel_c    = '0;
        seg30_c      = SEG_RESET;
        seg74_c      = SEG_RESET;
        case (state)
            ST_BLANK: if (cnt_next_c == CNT_W'(DEAD_CYC)) state_next_c = ST_DRIVE;
            ST_DRIVE: begin
                if (wrap_c && (DEAD_CYC != 0)) state_next_c = ST_BLANK;
                tub_sel_c[idx]          = active.en_mask[idx];
                tub_sel_c[{1'b1, idx}]  = active.en_mask[{1'b1, idx}];
            end
            default: state_next_c = ST_INIT;
        endcase
        if (active.en_mask[idx])
            seg30_c = font_lo_c | {7'b0, active.dp_mask[idx]};
        if (active.en_mask[{1'b1, idx}])
            seg74_c = font_hi_c | {7'b0, active.dp_mask[{1'b1, idx}]};
    end

    // Counters, register sets and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt     <= '0;
            idx     <= '0;
            pending <= REG_RESET;
            active  <= REG_RESET;
            tub_sel <= TUB_RESET;
            seg30   <= SEG_RESET;
            seg74   <= SEG_RESET;
        end else begin
            cnt     <= cnt_next_c;
            idx     <= idx_next_c;
            pending <= pending_next_c;
            // Frame boundary: take pending including any same-edge write
            if (frame_c) active <= pending_next_c;
            tub_sel <= tub_sel_c;
            seg30   <= seg30_c;
            seg74   <= seg74_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, DEAD_CYC=2.
// Edge numbers count rising edges since reset release; the output after
// edge e reflects cnt=(e-1)%8, idx=((e-1)/8)%4. Frame boundaries land on
// edges 32, 64, 96, ...
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rstn;
    logic        seg_we;
    logic [1:0]  seg_addr;
    logic [15:0] seg_wdata;
    logic [7:0]  tub_sel, seg30, seg74;

    seg_scan_driver #(.SCAN_DIV(8), .DEAD_CYC(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .seg_we    (seg_we),
        .seg_addr  (seg_addr),
        .seg_wdata (seg_wdata),
        .tub_sel   (tub_sel),
        .seg30     (seg30),
        .seg74     (seg74)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_no;
        logic        we;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic        chk;
        logic [7:0]  tub;
        logic [7:0]  s30;
        logic [7:0]  s74;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   edge_cnt;
    int   n_checks;
    int   n_errors;

    function automatic vec_t mk(int e, logic we, logic [1:0] a, logic [15:0] d,
                                logic c, logic [7:0] t, logic [7:0] s3,
                                logic [7:0] s7, string n);
        vec_t v;
        v.edge_no = e; v.we = we; v.addr = a; v.wdata = d; v.chk = c;
        v.tub = t; v.s30 = s3; v.s74 = s7; v.name = n;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
    endtask

    task automatic check(string name, logic [7:0] t, logic [7:0] s3, logic [7:0] s7);
        n_checks++;
        if (tub_sel !== t || seg30 !== s3 || seg74 !== s7) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got tub=%h seg30=%h seg74=%h, want tub=%h seg30=%h seg74=%h",
                     name, edge_cnt, tub_sel, seg30, seg74, t, s3, s7);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        edge_cnt = 0;
        rstn = 1'b0; seg_we = 1'b0; seg_addr = 2'd0; seg_wdata = 16'h0;

        // Reset release and idle scanning with default contents
        vecs.push_back(mk(  1, 0, 0, 16'h0,    1, 8'h00, 8'hFC, 8'hFC, "rel_c1"));
        vecs.push_back(mk(  2, 0, 0, 16'h0,    1, 8'h00, 8'hFC, 8'hFC, "rel_c2"));
        vecs.push_back(mk(  3, 0, 0, 16'h0,    1, 8'h11, 8'hFC, 8'hFC, "rel_c3"));
        vecs.push_back(mk(  8, 0, 0, 16'h0,    1, 8'h11, 8'hFC, 8'hFC, "slot0_end"));
        vecs.push_back(mk(  9, 0, 0, 16'h0,    1, 8'h00, 8'hFC, 8'hFC, "slot1_blank"));
        vecs.push_back(mk( 11, 0, 0, 16'h0,    1, 8'h22, 8'hFC, 8'hFC, "slot1_drive"));
        vecs.push_back(mk( 27, 0, 0, 16'h0,    1, 8'h88, 8'hFC, 8'hFC, "slot3_drive"));
        // Mid-frame digit writes, visible only from the frame after edge 64
        vecs.push_back(mk( 40, 1, 0, 16'h3210, 1, 8'h11, 8'hFC, 8'hFC, "wr_lo"));
        vecs.push_back(mk( 41, 1, 1, 16'h7654, 0, 8'h00, 8'h00, 8'h00, "wr_hi"));
        vecs.push_back(mk( 51, 0, 0, 16'h0,    1, 8'h44, 8'hFC, 8'hFC, "old_slot2"));
        vecs.push_back(mk( 63, 0, 0, 16'h0,    1, 8'h88, 8'hFC, 8'hFC, "old_slot3"));
        vecs.push_back(mk( 64, 0, 0, 16'h0,    1, 8'h88, 8'hFC, 8'hFC, "old_boundary"));
        vecs.push_back(mk( 65, 0, 0, 16'h0,    1, 8'h00, 8'hFC, 8'h66, "new_blank"));
        vecs.push_back(mk( 67, 0, 0, 16'h0,    1, 8'h11, 8'hFC, 8'h66, "new_slot0"));
        vecs.push_back(mk( 75, 0, 0, 16'h0,    1, 8'h22, 8'h60, 8'hB6, "new_slot1"));
        vecs.push_back(mk( 83, 0, 0, 16'h0,    1, 8'h44, 8'hDA, 8'hBE, "new_slot2"));
        vecs.push_back(mk( 91, 0, 0, 16'h0,    1, 8'h88, 8'hF2, 8'hE0, "new_slot3"));
        // Control register: digit 0 disabled with dp set, then dp on enabled digits
        vecs.push_back(mk(100, 1, 2, 16'h01FE, 1, 8'h11, 8'hFC, 8'h66, "wr_ctrl"));
        vecs.push_back(mk(131, 0, 0, 16'h0,    1, 8'h10, 8'h00, 8'h66, "dig0_off"));
        vecs.push_back(mk(139, 0, 0, 16'h0,    1, 8'h22, 8'h60, 8'hB6, "dig1_on"));
        vecs.push_back(mk(150, 1, 2, 16'h11FF, 0, 8'h00, 8'h00, 8'h00, "wr_ctrl2"));
        vecs.push_back(mk(163, 0, 0, 16'h0,    1, 8'h11, 8'hFD, 8'h67, "dp_on"));
        vecs.push_back(mk(170, 1, 2, 16'h00FF, 0, 8'h00, 8'h00, 8'h00, "wr_ctrl3"));
        vecs.push_back(mk(171, 0, 0, 16'h0,    1, 8'h22, 8'h60, 8'hB6, "dp_slot1"));
        vecs.push_back(mk(191, 0, 0, 16'h0,    1, 8'h88, 8'hF2, 8'hE0, "pre_bypass"));
        // Write on the frame-boundary edge goes straight to the display
        vecs.push_back(mk(192, 1, 0, 16'h000F, 1, 8'h88, 8'hF2, 8'hE0, "bypass_edge"));
        vecs.push_back(mk(195, 0, 0, 16'h0,    1, 8'h11, 8'h8E, 8'h66, "bypass_slot0"));
        // Reserved address must change nothing
        vecs.push_back(mk(200, 1, 3, 16'hFFFF, 1, 8'h11, 8'h8E, 8'h66, "addr3_wr"));
        vecs.push_back(mk(203, 0, 0, 16'h0,    1, 8'h22, 8'hFC, 8'hB6, "addr3_s1"));
        vecs.push_back(mk(227, 0, 0, 16'h0,    1, 8'h11, 8'h8E, 8'h66, "addr3_nf0"));
        vecs.push_back(mk(235, 0, 0, 16'h0,    1, 8'h22, 8'hFC, 8'hB6, "addr3_nf1"));
        vecs.push_back(mk(243, 0, 0, 16'h0,    1, 8'h44, 8'hFC, 8'hBE, "addr3_nf2"));

        // Hand sequence: reset held, outputs all zero
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", 8'h00, 8'h00, 8'h00);
        rstn = 1'b1;
        edge_cnt = 0;

        foreach (vecs[i]) begin
            while (edge_cnt < vecs[i].edge_no - 1) tick();
            seg_we    = vecs[i].we;
            seg_addr  = vecs[i].addr;
            seg_wdata = vecs[i].wdata;
            tick();
            seg_we = 1'b0;
            if (vecs[i].chk) check(vecs[i].name, vecs[i].tub, vecs[i].s30, vecs[i].s74);
        end

        // Hand sequence: reset at idx 2, cnt 5 (edge 278) with a write that must be dropped
        while (edge_cnt < 277) tick();
        rstn = 1'b0; seg_we = 1'b1; seg_addr = 2'd0; seg_wdata = 16'hAAAA;
        tick();
        rstn = 1'b1; seg_we = 1'b0;
        check("rst_mid", 8'h00, 8'h00, 8'h00);
        edge_cnt = 0;
        tick();
        check("rst_c1", 8'h00, 8'hFC, 8'hFC);
        tick(); tick();
        check("rst_c3", 8'h11, 8'hFC, 8'hFC);
        while (edge_cnt < 11) tick();
        check("rst_slot1", 8'h22, 8'hFC, 8'hFC);
        while (edge_cnt < 35) tick();
        check("rst_nf_slot0", 8'h11, 8'hFC, 8'hFC);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
